// File: rtl/program_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : program_loader                                                |
// | Purpose  : Streams a program image through a small prefetch FIFO into    |
// |            the CPU RAM, then releases the CPU from reset.                |
// | Options  : LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module program_loader #(
    parameter int MEM_DEPTH      = 16,
    parameter int FIFO_DEPTH     = 2,
    parameter int RESTART_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         start,
    input  logic                         abort,
    input  logic [7:0]                   data_in,
    input  logic                         data_valid,
    output logic                         data_ready,
    input  logic                         read_ui_in,
    input  logic                         done_load,
    output logic                         programming,
    output logic                         cpu_resetn,
    output logic [7:0]                   bus_data,
    output logic                         bus_oe,
    output logic [$clog2(MEM_DEPTH)-1:0] load_addr,
    output logic                         running,
    output logic                         error
);
    localparam int c_ADDR_W = $clog2(MEM_DEPTH);
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
`ifdef LOADER_CHECKSUM_EN
    localparam int c_ACC_LIMIT = MEM_DEPTH + 1;
`else
    localparam int c_ACC_LIMIT = MEM_DEPTH;
`endif
    localparam int c_ACC_W = $clog2(c_ACC_LIMIT + 1);
    localparam int c_RST_W = $clog2(RESTART_CYCLES + 1);

    localparam logic [c_ACC_W-1:0]  c_ACC_MAX   = c_ACC_W'(c_ACC_LIMIT);
    localparam logic [c_ADDR_W-1:0] c_LAST_ADDR = c_ADDR_W'(MEM_DEPTH - 1);
    localparam logic [c_PTR_W:0]    c_FIFO_FULL = (c_PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [c_RST_W-1:0]  c_RST_LAST  = c_RST_W'(RESTART_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREFETCH = 3'd1,
        S_LOAD     = 3'd2,
        S_RESTART  = 3'd3,
        S_RUN      = 3'd4,
        S_ERROR    = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [7:0]           r_fifo_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic [c_ACC_W-1:0]   r_accepted;
    logic [c_ADDR_W-1:0]  r_load_addr;
    logic [c_RST_W-1:0]   r_rst_cnt;
    logic                 r_programming;
    logic                 r_cpu_resetn;

    logic w_fifo_full, w_fifo_empty, w_push, w_pop, w_pop_data, w_pop_cks;
    logic w_last_word, w_underrun, w_flush, w_cks_wait;
    logic [7:0] w_head;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_sum;
    logic       r_cks_wait;
    logic       w_cks_ok;
    assign w_cks_wait = r_cks_wait;
    assign w_pop_cks  = (r_state == S_LOAD) && r_cks_wait && !w_fifo_empty;
    assign w_cks_ok   = (w_head == r_sum);
`else
    assign w_cks_wait = 1'b0;
    assign w_pop_cks  = 1'b0;
`endif

    assign w_head       = r_fifo_mem[r_rd_ptr];
    assign w_fifo_full  = (r_count == c_FIFO_FULL);
    assign w_fifo_empty = (r_count == '0);
    assign data_ready   = ((r_state == S_PREFETCH) || (r_state == S_LOAD)) &&
                          !w_fifo_full && (r_accepted < c_ACC_MAX);
    assign w_push       = data_valid && data_ready;
    // A word request against an empty FIFO is fatal; the byte is never counted.
    assign w_underrun   = (r_state == S_LOAD) && read_ui_in && w_fifo_empty && !w_cks_wait;
    assign w_pop_data   = (r_state == S_LOAD) && done_load && !w_fifo_empty && !w_cks_wait;
    assign w_last_word  = w_pop_data && (r_load_addr == c_LAST_ADDR);
    assign w_pop        = w_pop_data || w_pop_cks;
    assign w_flush      = (w_state_nxt == S_IDLE && r_state != S_IDLE) ||
                          (w_state_nxt == S_PREFETCH && r_state != S_PREFETCH);

    assign programming = r_programming;
    assign cpu_resetn  = r_cpu_resetn;
    assign bus_data    = w_head;
    assign bus_oe      = read_ui_in && (r_state == S_LOAD) && !w_cks_wait;
    assign load_addr   = r_load_addr;
    assign running     = (r_state == S_RUN);
    assign error       = (r_state == S_ERROR);

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_RUN, S_ERROR: begin
                    if (start) w_state_nxt = S_PREFETCH;
                end
                S_PREFETCH: begin
                    if (w_fifo_full || r_accepted == c_ACC_MAX) w_state_nxt = S_LOAD;
                end
                S_LOAD: begin
                    if (w_underrun) begin
                        w_state_nxt = S_ERROR;
`ifdef LOADER_CHECKSUM_EN
                    end else if (w_pop_cks) begin
                        w_state_nxt = w_cks_ok ? S_RESTART : S_ERROR;
`else
                    end else if (w_last_word) begin
                        w_state_nxt = S_RESTART;
`endif
                    end
                end
                S_RESTART: begin
                    if (r_rst_cnt == c_RST_LAST) w_state_nxt = S_RUN;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_accepted    <= '0;
            r_load_addr   <= '0;
            r_rst_cnt     <= '0;
            r_programming <= 1'b0;
            r_cpu_resetn  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_fifo_mem[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Registered from the next state so both controls are glitch-free.
            r_programming <= (w_state_nxt == S_LOAD);
            r_cpu_resetn  <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_RUN);
            r_rst_cnt     <= (r_state == S_RESTART) ? r_rst_cnt + 1'b1 : '0;
            if (w_flush) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
                r_accepted  <= '0;
                r_load_addr <= '0;
            end else begin
                if (w_push) begin
                    r_fifo_mem[r_wr_ptr] <= data_in;
                    r_wr_ptr             <= r_wr_ptr + 1'b1;
                    r_accepted           <= r_accepted + 1'b1;
                end
                if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
                if (w_pop_data && !w_last_word) r_load_addr <= r_load_addr + 1'b1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sum      <= '0;
            r_cks_wait <= 1'b0;
        end else if (w_flush) begin
            r_sum      <= '0;
            r_cks_wait <= 1'b0;
        end else begin
            if (w_pop_data)  r_sum      <= r_sum + w_head;
            if (w_last_word) r_cks_wait <= 1'b1;
            if (w_pop_cks)   r_cks_wait <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_program_loader                                             |
// | Purpose  : Self-checking bench: control vector table plus scoreboarded    |
// |            image loads with a modelled source and control block.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_program_loader;
    localparam int MEM_DEPTH = 16;
`ifdef LOADER_CHECKSUM_EN
    localparam int SRC_N = MEM_DEPTH + 1;
`else
    localparam int SRC_N = MEM_DEPTH;
`endif

    logic       clk = 1'b0;
    logic       resetn, start, abort, data_valid, read_ui_in, done_load;
    logic [7:0] data_in;
    logic       data_ready, programming, cpu_resetn, bus_oe, running, error;
    logic [7:0] bus_data;
    logic [3:0] load_addr;

    program_loader #(.MEM_DEPTH(MEM_DEPTH), .FIFO_DEPTH(2), .RESTART_CYCLES(2)) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
        .read_ui_in(read_ui_in), .done_load(done_load),
        .programming(programming), .cpu_resetn(cpu_resetn),
        .bus_data(bus_data), .bus_oe(bus_oe), .load_addr(load_addr),
        .running(running), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         start;
        bit         abort;
        bit         dv;
        logic [7:0] din;
        logic [4:0] exp;   // {data_ready, programming, cpu_resetn, running, error}
    } vec_t;

    vec_t       vecs [12];
    int         checks = 0;
    int         failures = 0;
    logic [7:0] img [SRC_N];
    logic [7:0] sb [$];
    int         src_idx, stall_at, ctl_words;
    bit         src_en, ctl_en, ctl_phase, underrun, lim_chk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One cycle: control-block model pops first, then the source offers a byte.
    task automatic step();
        @(negedge clk);
        read_ui_in = 1'b0;
        done_load  = 1'b0;
        if (ctl_en && programming && ctl_words < MEM_DEPTH) begin
            if (ctl_phase) begin
                read_ui_in = 1'b1;
                done_load  = 1'b1;
                #1;
                chk("bus_oe", bus_oe, 1);
                if (sb.size() > 0) begin
                    chk("bus_data", bus_data, sb.pop_front());
                    ctl_words++;
                end else begin
                    underrun = 1'b1;
                    ctl_en   = 1'b0;
                end
            end
            ctl_phase = !ctl_phase;
        end
        data_valid = 1'b0;
        if (src_en && src_idx < SRC_N && src_idx != stall_at) begin
            data_valid = 1'b1;
            data_in    = img[src_idx];
        end
        if (data_valid && data_ready) begin
            sb.push_back(data_in);
            src_idx++;
        end
    endtask

    task automatic begin_load(input int stall);
        sb.delete();
        src_idx = 0; stall_at = stall; ctl_words = 0;
        ctl_phase = 1'b1; underrun = 1'b0; lim_chk = 1'b0;
        ctl_en = 1'b1; src_en = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_to_end();
        bit was_full;
        for (int i = 0; i < 400 && !(ctl_words == MEM_DEPTH || underrun); i++) begin
            was_full = (src_idx == SRC_N);
            step();
            if (was_full && programming && sb.size() < 2 && !lim_chk) begin
                chk("ready_after_limit", data_ready, 0);
                lim_chk = 1'b1;
            end
        end
        if (!(ctl_words == MEM_DEPTH || underrun)) chk("load_timeout", 0, 1);
    endtask

    task automatic finish_load(input bit ok);
        for (int n = 0; n < 20 && programming; n++) step();
        if (programming) chk("load_exit_timeout", 0, 1);
        if (ok) begin
            chk("restart1_cpu_resetn", cpu_resetn, 0);
            chk("restart1_running", running, 0);
            chk("restart_load_addr", load_addr, MEM_DEPTH - 1);
            step();
            chk("restart2_cpu_resetn", cpu_resetn, 0);
            chk("restart2_running", running, 0);
            step();
            chk("run_running", running, 1);
            chk("run_cpu_resetn", cpu_resetn, 1);
            chk("run_programming", programming, 0);
        end else begin
            chk("cks_error", error, 1);
            chk("cks_error_cpu_resetn", cpu_resetn, 0);
        end
    endtask

    initial begin
        vecs[0]  = '{0, 0, 0, 8'h00, 5'b00000};
        vecs[1]  = '{1, 0, 0, 8'h00, 5'b10000};
        vecs[2]  = '{0, 1, 0, 8'h00, 5'b00000};
        vecs[3]  = '{1, 1, 0, 8'h00, 5'b00000};
        vecs[4]  = '{1, 0, 0, 8'h00, 5'b10000};
        vecs[5]  = '{0, 0, 1, 8'hAA, 5'b10000};
        vecs[6]  = '{0, 0, 1, 8'hBB, 5'b00000};
        vecs[7]  = '{0, 0, 0, 8'h00, 5'b01100};
        vecs[8]  = '{0, 1, 0, 8'h00, 5'b00000};
        vecs[9]  = '{1, 0, 0, 8'h00, 5'b10000};
        vecs[10] = '{0, 0, 0, 8'h00, 5'b10000};
        vecs[11] = '{0, 1, 0, 8'h00, 5'b00000};

        resetn = 1'b0; start = 1'b0; abort = 1'b0; data_valid = 1'b0;
        data_in = 8'h00; read_ui_in = 1'b0; done_load = 1'b0;
        src_en = 1'b0; ctl_en = 1'b0; stall_at = -1; src_idx = 0;
        ctl_words = 0; ctl_phase = 1'b1; underrun = 1'b0; lim_chk = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_outputs", {data_ready, programming, cpu_resetn, running, error, bus_oe}, 0);
        chk("rst_bus_data", bus_data, 0);
        chk("rst_load_addr", load_addr, 0);
        resetn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            start = vecs[i].start; abort = vecs[i].abort;
            data_valid = vecs[i].dv; data_in = vecs[i].din;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {data_ready, programming, cpu_resetn, running, error}, vecs[i].exp);
        end
        start = 1'b0; abort = 1'b0; data_valid = 1'b0;

        // Continuous stream 0x00..0x0F from IDLE.
        for (int i = 0; i < SRC_N; i++) img[i] = 8'(i);
`ifdef LOADER_CHECKSUM_EN
        img[MEM_DEPTH] = 8'h78;
`endif
        begin_load(-1);
        run_to_end();
        finish_load(1'b1);

        // Reload straight from RUN with a new image.
        for (int i = 0; i < SRC_N; i++) img[i] = 8'(8'h80 + i * 3);
`ifdef LOADER_CHECKSUM_EN
        img[MEM_DEPTH] = 8'h68;
`endif
        begin_load(-1);
        run_to_end();
        finish_load(1'b1);

        // Source stalls after byte 5: underrun on word 6.
        for (int i = 0; i < SRC_N; i++) img[i] = 8'(8'h20 + i);
        begin_load(6);
        run_to_end();
        chk("underrun_seen", underrun, 1);
        step();
        chk("err_error", error, 1);
        chk("err_cpu_resetn", cpu_resetn, 0);
        chk("err_programming", programming, 0);
        chk("err_load_addr", load_addr, 6);
        for (int i = 0; i < SRC_N; i++) img[i] = 8'(8'h40 + i);
`ifdef LOADER_CHECKSUM_EN
        img[MEM_DEPTH] = 8'h78;
`endif
        begin_load(-1);
        run_to_end();
        finish_load(1'b1);

        // Abort at load_addr 9.
        for (int i = 0; i < SRC_N; i++) img[i] = 8'(8'h60 + i);
        begin_load(-1);
        for (int i = 0; i < 200 && ctl_words < 9; i++) step();
        ctl_en = 1'b0; src_en = 1'b0;
        step();
        chk("abort_pre_load_addr", load_addr, 9);
        chk("abort_pre_programming", programming, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_idle", {data_ready, programming, cpu_resetn, running, error}, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("abort_flushed_ready", data_ready, 1);
        chk("abort_flushed_prog", programming, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;

`ifdef LOADER_CHECKSUM_EN
        for (int i = 0; i < MEM_DEPTH; i++) img[i] = 8'h01;
        img[MEM_DEPTH] = 8'h10;
        begin_load(-1);
        run_to_end();
        finish_load(1'b1);
        img[MEM_DEPTH] = 8'h11;
        begin_load(-1);
        run_to_end();
        finish_load(1'b0);
`endif

        // Asynchronous reset mid-LOAD.
        for (int i = 0; i < SRC_N; i++) img[i] = 8'(8'hC0 + i);
        begin_load(-1);
        for (int i = 0; i < 200 && ctl_words < 4; i++) step();
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_outputs",
            {data_ready, programming, cpu_resetn, running, error, bus_oe}, 0);
        chk("async_rst_bus_data", bus_data, 0);
        chk("async_rst_load_addr", load_addr, 0);
        @(negedge clk);
        ctl_en = 1'b0; src_en = 1'b0;
        read_ui_in = 1'b0; done_load = 1'b0; data_valid = 1'b0;
        resetn = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/program_loader.md
Name: program_loader

Overview:
- Sequencer that loads a program image from an external byte stream into the CPU's 16-word RAM, then starts the CPU.
- Drives the control block's `programming` input and its reset, and supplies the shared bus with each byte when the control block asserts `read_ui_in`.
- Counts `done_load` completions and holds the CPU in reset whenever no valid image is present.
- Sits between the top-level pin logic and the control block / bus mux.

Parameters:
- MEM_DEPTH, 16, number of RAM words to load per image.
- FIFO_DEPTH, 2, depth of the input prefetch buffer (power of two, ≥2).
- RESTART_CYCLES, 2, cycles `cpu_resetn` is held low between load completion and run.

Ports:
- clk  in  1  system clock; all loader state changes on posedge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  level-sampled; begins a load from IDLE, RUN or ERROR.
- abort  in  1  returns to IDLE from any state; has priority over start.
- data_in  in  8  program byte from the external source.
- data_valid  in  1  data_in valid.
- data_ready  out  1  loader accepts data_in this cycle.
- read_ui_in  in  1  from control block; RAM data is being latched from the bus.
- done_load  in  1  from control block; current RAM write complete.
- programming  out  1  to control block.
- cpu_resetn  out  1  active-low reset to the control block, PC and registers.
- bus_data  out  8  byte presented to the bus, FIFO head.
- bus_oe  out  1  loader drives the bus; equals read_ui_in AND state==LOAD.
- load_addr  out  clog2(MEM_DEPTH)  words written so far in this image.
- running  out  1  state==RUN.
- error  out  1  state==ERROR.

Behaviour:
- Async reset → IDLE. Reset values: FIFO empty, counters 0, programming=0, cpu_resetn=0, data_ready=0, bus_data=0, bus_oe=0, running=0, error=0.
- Handshake: a byte transfers on a posedge with data_valid & data_ready. `accepted` counts transfers; data_ready = (state ∈ {PREFETCH, LOAD}) & !fifo_full & (accepted < MEM_DEPTH). data_valid outside these states is ignored. Push and pop in the same cycle are legal; the occupancy count is unchanged.
- IDLE: cpu_resetn=0, programming=0. start → PREFETCH; FIFO, accepted and load_addr are cleared.
- PREFETCH: cpu_resetn=0. Fills the FIFO. Moves to LOAD when the FIFO is full or accepted==MEM_DEPTH.
- LOAD: cpu_resetn=1, programming=1. The control block runs programming cycles, one RAM word per instruction cycle.
  - Each posedge with done_load=1 pops the FIFO and increments load_addr.
  - When the pop brings load_addr to MEM_DEPTH → RESTART, with load_addr saturated at MEM_DEPTH-1.
- Underrun: read_ui_in sampled high in LOAD with the FIFO empty → ERROR. The bad byte is not counted.
- RESTART: cpu_resetn=0, programming=0 for exactly RESTART_CYCLES posedges, then → RUN. This returns the PC to 0 and the control block to its hold stage.
- RUN: cpu_resetn=1, programming=0, running=1. start → PREFETCH (reload, counters cleared).
- ERROR: cpu_resetn=0, programming=0, error=1. start → PREFETCH (FIFO flushed).
- abort in any state → IDLE next posedge, FIFO flushed.
- programming and cpu_resetn are registered outputs, glitch-free, and change only on posedge.
- bus_data is combinational from the FIFO head register.
- The control block samples on negedge, so its read_ui_in and done_load are stable at the loader's posedge.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After MEM_DEPTH data bytes, one extra checksum byte is accepted; the acceptance limit becomes MEM_DEPTH+1.
  - An 8-bit modulo-256 sum of all popped data bytes is kept.
  - On reaching the last word, the loader waits in LOAD for the checksum byte and compares.
  - Match → RESTART. Mismatch → ERROR.
  - The checksum byte is never presented on the bus.
- Undefined: no checksum byte and no sum logic; behaviour is exactly as above.

Test Plan:
- Reset, start, stream bytes 0x00..0x0F continuously → 16 done_load pops with bus_data = 0x00..0x0F in order, RESTART holds cpu_resetn low for 2 cycles, then running=1 with programming=0.
- Source stalls after byte 5 until read_ui_in asserts for word 6 with the FIFO empty → error=1, cpu_resetn=0, load_addr=6; a following start reloads cleanly.
- Assert abort mid-load at load_addr=9 → IDLE next cycle, programming=0, cpu_resetn=0, FIFO empty.
- Assert resetn low asynchronously mid-LOAD → all outputs take reset values immediately, before the next clock edge.
- In RUN, assert start with a new image → PREFETCH, second image loaded, running again; data_ready=0 after 16 accepted bytes.
- With LOADER_CHECKSUM_EN: image 0x01×16 plus checksum 0x10 → RUN; the same image with checksum 0x11 → ERROR.
